// File: rtl/esp32_boot_sequencer.sv
// Purpose: drives the nDTR/nRTS pattern that resets the ESP32 into run mode or into its serial bootloader.
// Latency: every output is registered. Host lines pass through in 1 cycle, and a sequence starts 1 cycle after start.
// Backpressure: there is none. A start that arrives while busy is dropped, not queued.
module esp32_boot_sequencer #(
    parameter int C_reset_time = 2500000,
    parameter int C_boot_time  = 1250000
) (
    input  logic i_clk_25mhz,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_mode,
    input  logic i_host_ndtr,
    input  logic i_host_nrts,
    output logic o_prog_ndtr,
    output logic o_prog_nrts,
    output logic o_busy,
    output logic o_done
);

    localparam int C_max = (C_reset_time > C_boot_time) ? C_reset_time : C_boot_time;
    localparam int C_cw  = $clog2(C_max + 1);

    // Terminal counts for each phase. The counter runs from 0 up to the terminal value inclusive.
    localparam logic [C_cw-1:0] C_rst_last  = C_cw'(C_reset_time - 1);
    localparam logic [C_cw-1:0] C_boot_last = C_cw'(C_boot_time - 1);

    // Line patterns, written as {ndtr,nrts}.
    localparam logic [1:0] C_lines_en_low  = 2'b10;
    localparam logic [1:0] C_lines_io0_low = 2'b01;
    localparam logic [1:0] C_lines_release = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_BOOT,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_cw-1:0]   r_cnt;
    logic [C_cw-1:0]   w_cnt_nxt;
    logic              r_mode;
    logic              w_mode_nxt;
    logic [1:0]        r_lines;
    logic [1:0]        w_lines_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    // State, counter and output registers. Reset aborts any sequence in progress and releases both lines.
    always_ff @(posedge i_clk_25mhz) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_lines <= C_lines_release;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_lines <= w_lines_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic. Output values are computed for the state being entered, so each output is one register deep.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + C_cw'(1);
        w_mode_nxt  = r_mode;
        w_lines_nxt = C_lines_release;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_lines_nxt = {i_host_ndtr, i_host_nrts};
                if (i_start) begin
                    w_state_nxt = S_RESET;
                    w_mode_nxt  = i_mode;
                    w_lines_nxt = C_lines_en_low;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RESET: begin
                w_lines_nxt = C_lines_en_low;
                if (r_cnt == C_rst_last) begin
                    w_cnt_nxt = '0;
                    if (r_mode) begin
                        // Both bits flip on the same edge, so the decoder never sees 00 or 11.
                        w_state_nxt = S_BOOT;
                        w_lines_nxt = C_lines_io0_low;
                    end else begin
                        w_state_nxt = S_FINISH;
                        w_lines_nxt = C_lines_release;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_BOOT: begin
                w_lines_nxt = C_lines_io0_low;
                if (r_cnt == C_boot_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FINISH;
                    w_lines_nxt = C_lines_release;
                    w_done_nxt  = 1'b1;
                end
            end
            S_FINISH: begin
                // Control goes back to the host on the very next cycle. A start seen here is dropped.
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_lines_nxt = {i_host_ndtr, i_host_nrts};
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_prog_ndtr = r_lines[1];
    assign o_prog_nrts = r_lines[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Purpose: exercises esp32_boot_sequencer with directed and random stimulus, checked against a schedule-based model.
// Latency: outputs are checked 1 time unit after every rising edge.
// Backpressure: not applicable. Stimulus is applied cycle by cycle.
module tb_esp32_boot_sequencer;

    localparam int C_reset_time = 4;
    localparam int C_boot_time  = 3;

    logic clk;
    logic rst;
    logic start;
    logic mode;
    logic host_ndtr;
    logic host_nrts;
    logic prog_ndtr;
    logic prog_nrts;
    logic busy;
    logic done;

    int n_assert;
    int n_fail;

    // Model state. sched holds {ndtr,nrts,busy,done} for every remaining busy cycle of the active sequence.
    logic [3:0] sched[$];
    logic [3:0] exp_out;
    int         cyc;

    esp32_boot_sequencer #(
        .C_reset_time(C_reset_time),
        .C_boot_time (C_boot_time)
    ) dut (
        .i_clk_25mhz(clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_host_ndtr(host_ndtr),
        .i_host_nrts(host_nrts),
        .o_prog_ndtr(prog_ndtr),
        .o_prog_nrts(prog_nrts),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle of inputs, advances the model across the edge, and checks the outputs 1 time unit later.
    task automatic step(input logic s, input logic m, input logic hd, input logic hn, input logic r);
        logic was_idle;
        start     = s;
        mode      = m;
        host_ndtr = hd;
        host_nrts = hn;
        rst       = r;
        @(posedge clk);
        cyc++;
        was_idle = (exp_out[1] == 1'b0);
        if (r) begin
            sched.delete();
            exp_out = 4'b1100;
        end else if (sched.size() > 0) begin
            exp_out = sched.pop_front();
        end else if (was_idle && s) begin
            for (int i = 0; i < C_reset_time; i++) sched.push_back(4'b1010);
            if (m) for (int i = 0; i < C_boot_time; i++) sched.push_back(4'b0110);
            sched.push_back(4'b1111);
            exp_out = sched.pop_front();
        end else begin
            exp_out = {hd, hn, 2'b00};
        end
        #1;
        n_assert++;
        assert ({prog_ndtr, prog_nrts} === exp_out[3:2]) else begin
            n_fail++;
            $error("FAIL lines cyc=%0d observed=%b expected=%b", cyc, {prog_ndtr, prog_nrts}, exp_out[3:2]);
        end
        n_assert++;
        assert (busy === exp_out[1]) else begin
            n_fail++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, exp_out[1]);
        end
        n_assert++;
        assert (done === exp_out[0]) else begin
            n_fail++;
            $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, exp_out[0]);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_out  = 4'b1100;
        start = 1'b0; mode = 1'b0; host_ndtr = 1'b0; host_nrts = 1'b0; rst = 1'b1;

        // Reset held for 3 cycles with host lines at 00, then one idle cycle with the host still at 00.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Idle forwarding: the host lines toggle and the outputs follow one cycle later.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Bootloader sequence. The host drives 00 throughout, and that must never reach the outputs.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Normal run sequence.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // A second start at N+2 is ignored, and so is a start held during FINISH.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during BOOT at N+6 aborts at once and done never pulses. The case with start and reset together follows.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
